// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a five-stage pipeline: tracks decode-to-writeback shadow state,
// derives stall/bubble controls combinationally and keeps saturating event counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  d_dstM,
  input  logic [2:0]  D_stat,
  input  logic        e_cnd,
  input  logic        m_err,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic        set_cc,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] bubble_cnt,
  output logic [15:0] mispred_cnt
);
  localparam logic [3:0] I_NOP = 4'd1;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ = 4'd6;
  localparam logic [3:0] I_JXX = 4'd7;
  localparam logic [3:0] I_RET = 4'd9;
  localparam logic [3:0] I_POPQ = 4'd11;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [3:0]  e_icode_q, e_icode_d, e_dstm_q, e_dstm_d, m_icode_q, m_icode_d;
  logic [2:0]  e_stat_q, e_stat_d, m_stat_q, m_stat_d, w_stat_q, w_stat_d;
  logic        halted_q, halted_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;
  logic        load_use, ret_busy, mispred, m_exc, w_exc, m_err_eff;

  // A memory error seen while reset is held must not raise controls.
  assign m_err_eff = m_err & ~reset;

  always_comb begin
    load_use = ((e_icode_q == I_MRMOVQ) || (e_icode_q == I_POPQ)) && (e_dstm_q != R_NONE) &&
               ((e_dstm_q == d_srcA) || (e_dstm_q == d_srcB));
    ret_busy = (D_icode == I_RET) || (e_icode_q == I_RET) || (m_icode_q == I_RET);
    mispred  = (e_icode_q == I_JXX) && !e_cnd;
    m_exc    = m_err_eff || (m_stat_q != S_AOK);
    w_exc    = (w_stat_q != S_AOK);
    F_stall  = load_use || ret_busy;
    D_stall  = load_use;
    D_bubble = mispred || (ret_busy && !load_use);
    E_bubble = mispred || load_use;
    M_bubble = m_exc || w_exc;
    W_stall  = w_exc;
    set_cc   = (e_icode_q == I_OPQ) && (e_stat_q == S_AOK) && !m_exc && !w_exc;
  end

  always_comb begin
    e_icode_d = E_bubble ? I_NOP : D_icode;
    e_dstm_d  = E_bubble ? R_NONE : d_dstM;
    e_stat_d  = E_bubble ? S_AOK : D_stat;
    m_icode_d = M_bubble ? I_NOP : e_icode_q;
    m_stat_d  = M_bubble ? S_AOK : e_stat_q;
    w_stat_d  = W_stall ? w_stat_q : (m_err_eff ? S_ADR : m_stat_q);
    halted_d  = halted_q || w_exc;
    stall_cnt_d   = stall_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    // Counters freeze once halted and never wrap.
    if (!halted_q) begin
      if (F_stall && (stall_cnt_q != CNT_MAX))     stall_cnt_d   = stall_cnt_q + 16'd1;
      if (E_bubble && (bubble_cnt_q != CNT_MAX))   bubble_cnt_d  = bubble_cnt_q + 16'd1;
      if (mispred && (mispred_cnt_q != CNT_MAX))   mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_icode_q     <= I_NOP;
      e_dstm_q      <= R_NONE;
      e_stat_q      <= S_AOK;
      m_icode_q     <= I_NOP;
      m_stat_q      <= S_AOK;
      w_stat_q      <= S_AOK;
      halted_q      <= 1'b0;
      stall_cnt_q   <= 16'd0;
      bubble_cnt_q  <= 16'd0;
      mispred_cnt_q <= 16'd0;
    end else begin
      e_icode_q     <= e_icode_d;
      e_dstm_q      <= e_dstm_d;
      e_stat_q      <= e_stat_d;
      m_icode_q     <= m_icode_d;
      m_stat_q      <= m_stat_d;
      w_stat_q      <= w_stat_d;
      halted_q      <= halted_d;
      stall_cnt_q   <= stall_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign halted      = halted_q;
  assign stall_cnt   = stall_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a stage-record model checked every negedge, plus
// directed sequences with hand-computed literal expectations.
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  D_icode = 4'd1, d_srcA = 4'hF, d_srcB = 4'hF, d_dstM = 4'hF;
  logic [2:0]  D_stat = 3'd1;
  logic        e_cnd = 1'b0, m_err = 1'b0;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [15:0] stall_cnt, bubble_cnt, mispred_cnt;

  int n_vec = 0;
  int n_bad = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstM(d_dstM), .D_stat(D_stat), .e_cnd(e_cnd), .m_err(m_err),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // Model: instruction records in flight in E and M, plus status in W.
  typedef struct packed { logic [3:0] icode; logic [3:0] dstm; logic [2:0] stat; } rec_t;
  typedef struct packed {
    logic fs, ds, db, eb, mb, ws, cc, mp;
  } ctl_t;

  rec_t       md_e, md_m;
  logic [2:0] md_w;
  bit         md_halted;
  int         md_stall, md_bub, md_misp;

  function automatic ctl_t model_ctl();
    ctl_t c;
    bit lu, rb, mexc, wexc;
    c = '0;
    if (reset) begin
      c.fs = (D_icode == 4'd9);
      c.db = (D_icode == 4'd9);
      return c;
    end
    lu   = (md_e.icode inside {4'd5, 4'd11}) && md_e.dstm != 4'hF &&
           (md_e.dstm == d_srcA || md_e.dstm == d_srcB);
    rb   = (D_icode == 4'd9) || (md_e.icode == 4'd9) || (md_m.icode == 4'd9);
    c.mp = (md_e.icode == 4'd7) && (e_cnd == 1'b0);
    mexc = m_err || md_m.stat != 3'd1;
    wexc = md_w != 3'd1;
    c.fs = lu || rb;
    c.ds = lu;
    c.db = c.mp || (rb && !lu);
    c.eb = c.mp || lu;
    c.mb = mexc || wexc;
    c.ws = wexc;
    c.cc = (md_e.icode == 4'd6) && md_e.stat == 3'd1 && !mexc && !wexc;
    return c;
  endfunction

  function automatic int sat_add(input int v, input bit inc);
    return (inc && v < 65535) ? v + 1 : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    ctl_t c;
    if (reset) begin
      md_e = '{4'd1, 4'hF, 3'd1};
      md_m = '{4'd1, 4'hF, 3'd1};
      md_w = 3'd1;
      md_halted = 1'b0;
      md_stall = 0; md_bub = 0; md_misp = 0;
    end else begin
      c = model_ctl();
      if (!md_halted) begin
        md_stall = sat_add(md_stall, c.fs);
        md_bub   = sat_add(md_bub, c.eb);
        md_misp  = sat_add(md_misp, c.mp);
      end
      md_halted = md_halted || (md_w != 3'd1);
      if (!c.ws) md_w = m_err ? 3'd3 : md_m.stat;
      md_m = c.mb ? rec_t'{4'd1, 4'hF, 3'd1} : rec_t'{md_e.icode, 4'hF, md_e.stat};
      md_e = c.eb ? rec_t'{4'd1, 4'hF, 3'd1} : rec_t'{D_icode, d_dstM, D_stat};
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ctl_t c;
    c = model_ctl();
    check("F_stall", {15'd0, F_stall}, {15'd0, c.fs});
    check("D_stall", {15'd0, D_stall}, {15'd0, c.ds});
    check("D_bubble", {15'd0, D_bubble}, {15'd0, c.db});
    check("E_bubble", {15'd0, E_bubble}, {15'd0, c.eb});
    check("M_bubble", {15'd0, M_bubble}, {15'd0, c.mb});
    check("W_stall", {15'd0, W_stall}, {15'd0, c.ws});
    check("set_cc", {15'd0, set_cc}, {15'd0, c.cc});
    check("halted", {15'd0, halted}, {15'd0, md_halted});
    check("stall_cnt", stall_cnt, 16'(md_stall));
    check("bubble_cnt", bubble_cnt, 16'(md_bub));
    check("mispred_cnt", mispred_cnt, 16'(md_misp));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_icode = 4'd1; d_srcA = 4'hF; d_srcB = 4'hF; d_dstM = 4'hF;
    D_stat = 3'd1; e_cnd = 1'b0; m_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset behaviour: only a RET in decode raises controls.
    tick();
    m_err = 1'b1; #2;
    check("rst_M_bubble", {15'd0, M_bubble}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    m_err = 1'b0; D_icode = 4'd9; #1;
    check("rst_ret_F_stall", {15'd0, F_stall}, 16'd1);
    check("rst_ret_D_bubble", {15'd0, D_bubble}, 16'd1);
    check("rst_ret_D_stall", {15'd0, D_stall}, 16'd0);
    do_reset();

    // Load-use: MRMOVQ to r3 followed by a reader of r3.
    D_icode = 4'd5; d_dstM = 4'd3;
    tick();
    D_icode = 4'd6; d_dstM = 4'hF; d_srcA = 4'd3; #2;
    check("lu_F_stall", {15'd0, F_stall}, 16'd1);
    check("lu_D_stall", {15'd0, D_stall}, 16'd1);
    check("lu_E_bubble", {15'd0, E_bubble}, 16'd1);
    tick();
    idle_inputs(); #2;
    check("lu_F_stall_after", {15'd0, F_stall}, 16'd0);
    check("lu_stall_cnt", stall_cnt, 16'd1);
    do_reset();

    // RET followed by NOPs stalls fetch for three cycles.
    D_icode = 4'd9;
    repeat (4) begin tick(); idle_inputs(); end
    #2;
    check("ret_stall_cnt", stall_cnt, 16'd3);
    check("ret_F_stall_done", {15'd0, F_stall}, 16'd0);
    do_reset();

    // Mispredicted then correctly predicted jump.
    D_icode = 4'd7;
    tick();
    D_icode = 4'd1; e_cnd = 1'b0; #2;
    check("mp_D_bubble", {15'd0, D_bubble}, 16'd1);
    check("mp_E_bubble", {15'd0, E_bubble}, 16'd1);
    tick(); #2;
    check("mp_cnt", mispred_cnt, 16'd1);
    D_icode = 4'd7;
    tick();
    D_icode = 4'd1; e_cnd = 1'b1; #2;
    check("taken_D_bubble", {15'd0, D_bubble}, 16'd0);
    check("taken_E_bubble", {15'd0, E_bubble}, 16'd0);
    tick(); e_cnd = 1'b0; #2;
    check("taken_mp_cnt", mispred_cnt, 16'd1);
    do_reset();

    // Memory exception with an OPQ in execute, leading to halt.
    D_icode = 4'd5;
    tick();
    D_icode = 4'd6;
    tick();
    D_icode = 4'd1; #2;
    check("opq_set_cc", {15'd0, set_cc}, 16'd1);
    m_err = 1'b1; #1;
    check("exc_M_bubble", {15'd0, M_bubble}, 16'd1);
    check("exc_set_cc", {15'd0, set_cc}, 16'd0);
    tick();
    m_err = 1'b0; #2;
    check("exc_W_stall", {15'd0, W_stall}, 16'd1);
    check("exc_halted_early", {15'd0, halted}, 16'd0);
    tick();
    D_icode = 4'd9; #2;
    check("exc_halted", {15'd0, halted}, 16'd1);
    repeat (3) tick();
    check("exc_frozen_stall_cnt", stall_cnt, 16'd0);
    do_reset();

    // Saturation: sustained fetch stall with a RET held in decode.
    D_icode = 4'd9;
    repeat (65540) tick();
    #2;
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    do_reset();

    // Asynchronous reset in the middle of a RET sequence.
    D_icode = 4'd9;
    tick();
    D_icode = 4'd1; #2;
    check("ar_F_stall_pre", {15'd0, F_stall}, 16'd1);
    reset = 1'b1; #1;
    check("ar_F_stall", {15'd0, F_stall}, 16'd0);
    check("ar_stall_cnt", stall_cnt, 16'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
